// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary-neural-network layer sequencer.
package bnn_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Counts set bits in a result vector of up to 16 neurons.
    function automatic int unsigned popcount_of(input logic [15:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bnn_layer_sequencer_if.sv
// Load channel and neuron-facing bus between the layer sequencer and its neighbours.
interface bnn_layer_sequencer_if
    import bnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic [DATA_W-1:0] x_out;
    logic [DATA_W-1:0] weight_out;
    logic              neuron_en;
    logic              o_neuron;

    modport master (
        input  load_valid,
        input  load_data,
        input  o_neuron,
        output load_ready,
        output x_out,
        output weight_out,
        output neuron_en
    );

    modport slave (
        output load_valid,
        output load_data,
        output o_neuron,
        input  load_ready,
        input  x_out,
        input  weight_out,
        input  neuron_en
    );
endinterface

// File: rtl/bnn_weight_bank.sv
// Weight bank: byte-serial writes through a wrapping pointer, indexed read for issue.
module bnn_weight_bank
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic [$clog2(NUM_NEURONS)-1:0] rd_addr,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           bank_full
);
    localparam int IW = $clog2(NUM_NEURONS);

    logic [DATA_W-1:0] bank [NUM_NEURONS];
    logic [IW-1:0]     wr_ptr;

    // bank_full is sticky: reloading after a wrap overwrites in order without clearing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            bank_full <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_ptr] <= wr_data;
            if (wr_ptr == IW'(NUM_NEURONS - 1)) begin
                wr_ptr    <= '0;
                bank_full <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    assign rd_data = bank[rd_addr];

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Drives one time-multiplexed binary neuron through a full layer and packs its result bits.
// Optional BNN_POPCOUNT_EN adds registered popcount/majority outputs.
module bnn_layer_sequencer
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NEURON_LAT  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    bnn_layer_sequencer_if.master                 nif,
    input  logic                                  start,
    input  logic [DATA_W-1:0]                     input_data,
    output logic                                  busy,
    output logic                                  bank_full,
    output logic [NUM_NEURONS-1:0]                result,
`ifdef BNN_POPCOUNT_EN
    output logic [$clog2(NUM_NEURONS+1)-1:0]      popcount,
    output logic                                  majority,
`endif
    output logic                                  result_valid
);
    localparam int IW = $clog2(NUM_NEURONS);

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [1:0]             drain_cnt;
    logic                   out_of_reset;
    logic [DATA_W-1:0]      x_q;
    logic [DATA_W-1:0]      rd_data;
    logic                   neuron_en;
    logic                   start_ok;
    logic                   last_issue;
    logic                   enter_done;
    logic                   cap_valid;
    logic [IW-1:0]          cap_idx;
    logic [NUM_NEURONS-1:0] result_next;

    assign start_ok       = (state == IDLE) && start && bank_full;
    assign nif.load_ready = out_of_reset && (state == IDLE) && !start;
    assign neuron_en      = (state == RUN);
    assign nif.neuron_en  = neuron_en;
    assign nif.weight_out = neuron_en ? rd_data : '0;
    assign nif.x_out      = x_q;
    assign busy           = (state == RUN) || (state == DRAIN);
    assign last_issue     = (state == RUN) && (idx == IW'(NUM_NEURONS - 1));
    assign enter_done     = (last_issue && (NEURON_LAT == 0)) ||
                            ((state == DRAIN) && (drain_cnt == 2'(NEURON_LAT - 1)));

    bnn_weight_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_W      (DATA_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (nif.load_valid && nif.load_ready),
        .wr_data   (nif.load_data),
        .rd_addr   (idx),
        .rd_data   (rd_data),
        .bank_full (bank_full)
    );

    // Each issue's {valid, index} travels NEURON_LAT stages so the returning bit lands in its slot.
    generate
        if (NEURON_LAT == 0) begin : g_nolat
            assign cap_valid = neuron_en;
            assign cap_idx   = idx;
        end else begin : g_lat
            logic [NEURON_LAT-1:0] pipe_v;
            logic [IW-1:0]         pipe_i [NEURON_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_v <= '0;
                    for (int j = 0; j < NEURON_LAT; j++) begin
                        pipe_i[j] <= '0;
                    end
                end else begin
                    pipe_v[0] <= neuron_en;
                    pipe_i[0] <= idx;
                    for (int j = 1; j < NEURON_LAT; j++) begin
                        pipe_v[j] <= pipe_v[j-1];
                        pipe_i[j] <= pipe_i[j-1];
                    end
                end
            end

            assign cap_valid = pipe_v[NEURON_LAT-1];
            assign cap_idx   = pipe_i[NEURON_LAT-1];
        end
    endgenerate

    always_comb begin
        result_next = result;
        if (cap_valid) begin
            result_next[cap_idx] = nif.o_neuron;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            drain_cnt    <= '0;
            out_of_reset <= 1'b0;
            x_q          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            result_valid <= enter_done;
            result       <= result_next;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state  <= RUN;
                        idx    <= '0;
                        x_q    <= input_data;
                        result <= '0;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        idx       <= '0;
                        drain_cnt <= '0;
                        state     <= (NEURON_LAT == 0) ? DONE : DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (enter_done) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BNN_POPCOUNT_EN
    localparam int PW = $clog2(NUM_NEURONS + 1);

    logic [PW-1:0] pop_next;

    assign pop_next = PW'(popcount_of(16'(result_next)));

    // Summary bits land together with the final result bit, on the edge entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            popcount <= '0;
            majority <= 1'b0;
        end else if (enter_done) begin
            popcount <= pop_next;
            majority <= (int'(pop_next) * 2) > NUM_NEURONS;
        end
    end
`endif

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Bench for bnn_layer_sequencer: directed and randomized loads/runs checked against
// a last-N-bytes bank model and an XNOR-popcount neuron reference.
module tb_bnn_layer_sequencer;

    localparam int N   = 8;
    localparam int LAT = 1;
    localparam int DW  = 8;
    localparam int WIN = 40;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          start      = 1'b0;
    logic [DW-1:0] input_data = '0;
    logic          busy;
    logic          bank_full;
    logic          result_valid;
    logic [N-1:0]  result;
`ifdef BNN_POPCOUNT_EN
    logic [$clog2(N+1)-1:0] popcount;
    logic                   majority;
    logic [$clog2(N+1)-1:0] rv_pop;
    logic                   rv_maj;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mbank [N];
    int            mptr;
    int            mcount;

    int            en_cnt;
    int            rv_cnt;
    int            rv_cyc;
    bit            busy_seen;
    logic [N-1:0]  rv_res;
    logic [DW-1:0] issued [$];

    bnn_layer_sequencer_if #(.DATA_W(DW)) nif ();

    bnn_layer_sequencer #(
        .NUM_NEURONS (N),
        .DATA_W      (DW),
        .NEURON_LAT  (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .nif          (nif),
        .start        (start),
        .input_data   (input_data),
        .busy         (busy),
        .bank_full    (bank_full),
        .result       (result),
`ifdef BNN_POPCOUNT_EN
        .popcount     (popcount),
        .majority     (majority),
`endif
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Environment neuron: registered XNOR-popcount threshold, one cycle of latency.
    always @(posedge clk)
        nif.o_neuron <= nif.neuron_en && ($countones(~(nif.x_out ^ nif.weight_out)) >= DW/2);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [N-1:0] model_result(input logic [DW-1:0] x);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[k] = ($countones(~(x ^ mbank[k])) >= DW/2);
        end
        return r;
    endfunction

    function automatic logic [31:0] issue_at(input int k);
        if (k < issued.size()) return 32'(issued[k]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) mbank[k] = '0;
        mptr   = 0;
        mcount = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        checkOutput({tag, "_busy"},         32'(busy), 0);
        checkOutput({tag, "_result_valid"}, 32'(result_valid), 0);
        checkOutput({tag, "_result"},       32'(result), 0);
        checkOutput({tag, "_bank_full"},    32'(bank_full), 0);
        checkOutput({tag, "_load_ready"},   32'(nif.load_ready), 0);
        checkOutput({tag, "_neuron_en"},    32'(nif.neuron_en), 0);
        checkOutput({tag, "_weight_out"},   32'(nif.weight_out), 0);
        checkOutput({tag, "_x_out"},        32'(nif.x_out), 0);
`ifdef BNN_POPCOUNT_EN
        checkOutput({tag, "_popcount"},     32'(popcount), 0);
        checkOutput({tag, "_majority"},     32'(majority), 0);
`endif
    endtask

    task automatic reset_and_check(input string tag);
        rst_n = 1'b0;
        #1 check_zero_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        checkOutput({tag, "_load_ready_after"}, 32'(nif.load_ready), 1);
    endtask

    task automatic load_byte(input logic [DW-1:0] b);
        @(negedge clk);
        nif.load_valid = 1'b1;
        nif.load_data  = b;
        #1 checkOutput("load_ready", 32'(nif.load_ready), 1);
        @(negedge clk);
        nif.load_valid = 1'b0;
        mbank[mptr] = b;
        mptr        = (mptr + 1) % N;
        mcount++;
        checkOutput("bank_full", 32'(bank_full), 32'(mcount >= N));
    endtask

    // One start pulse (optionally with a competing load offer), then a fixed observation window.
    task automatic applyStimulus(input logic [DW-1:0] x, input bit offer, input logic [DW-1:0] b);
        @(negedge clk);
        start          = 1'b1;
        input_data     = x;
        nif.load_valid = offer;
        nif.load_data  = b;
        #1 checkOutput("load_ready_with_start", 32'(nif.load_ready), 0);
        @(negedge clk);
        start          = 1'b0;
        nif.load_valid = 1'b0;
        input_data     = DW'($urandom);
        en_cnt    = 0;
        rv_cnt    = 0;
        rv_cyc    = -1;
        busy_seen = 1'b0;
        rv_res    = '0;
        issued.delete();
        for (int c = 0; c < WIN; c++) begin
            if (nif.neuron_en) begin
                en_cnt++;
                issued.push_back(nif.weight_out);
            end
            if (busy) busy_seen = 1'b1;
            if (result_valid) begin
                rv_cnt++;
                rv_cyc = c;
                rv_res = result;
`ifdef BNN_POPCOUNT_EN
                rv_pop = popcount;
                rv_maj = majority;
`endif
            end
            @(negedge clk);
        end
    endtask

    task automatic run_and_check(input string tag, input logic [DW-1:0] x, input bit offer, input logic [DW-1:0] b);
        logic [N-1:0] exp_res;
        exp_res = model_result(x);
        applyStimulus(x, offer, b);
        checkOutput({tag, "_en_cycles"},   32'(en_cnt), N);
        checkOutput({tag, "_rv_count"},    32'(rv_cnt), 1);
        checkOutput({tag, "_rv_cycle"},    32'(rv_cyc), N + LAT);
        checkOutput({tag, "_result"},      32'(rv_res), 32'(exp_res));
        checkOutput({tag, "_result_hold"}, 32'(result), 32'(exp_res));
        checkOutput({tag, "_x_out"},       32'(nif.x_out), 32'(x));
        checkOutput({tag, "_busy_end"},    32'(busy), 0);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("%s_issue%0d", tag, k), issue_at(k), 32'(mbank[k]));
        end
`ifdef BNN_POPCOUNT_EN
        checkOutput({tag, "_popcount"}, 32'(rv_pop), 32'($countones(exp_res)));
        checkOutput({tag, "_majority"}, 32'(rv_maj), 32'($countones(exp_res) * 2 > N));
`endif
    endtask

    task automatic check_ignored(input string tag);
        applyStimulus(DW'($urandom), 1'b0, '0);
        checkOutput({tag, "_en_cycles"}, 32'(en_cnt), 0);
        checkOutput({tag, "_rv_count"},  32'(rv_cnt), 0);
        checkOutput({tag, "_busy_seen"}, 32'(busy_seen), 0);
    endtask

    initial begin
        logic [DW-1:0] x;
        nif.load_valid = 1'b0;
        nif.load_data  = '0;
        model_clear();

        #2 reset_and_check("por");

        $display("[TB] start with an empty bank");
        check_ignored("t1");

        $display("[TB] weights 0..7, x=FF");
        for (int k = 0; k < N; k++) load_byte(DW'(k));
        run_and_check("t2", 8'hFF, 1'b0, '0);

        $display("[TB] all-ones bank");
        for (int k = 0; k < N; k++) load_byte(8'hFF);
        run_and_check("t3a", 8'hFF, 1'b0, '0);
        checkOutput("t3a_const", 32'(result), 32'h0000_00FF);
        run_and_check("t3b", 8'h00, 1'b0, '0);
        checkOutput("t3b_const", 32'(result), 0);
`ifdef BNN_POPCOUNT_EN
        checkOutput("t3b_pop_const", 32'(popcount), 0);
        checkOutput("t3b_maj_const", 32'(majority), 0);
`endif

        $display("[TB] load offered together with start");
        for (int k = 0; k < N; k++) load_byte(DW'($urandom));
        run_and_check("t4", DW'($urandom), 1'b1, 8'h5A);

        $display("[TB] ten-byte wrap");
        for (int k = 0; k < 10; k++) load_byte(DW'(8'hA0 + k));
        run_and_check("t5", DW'($urandom), 1'b0, '0);
        checkOutput("t5_issue0_const", issue_at(0), 32'h0000_00A8);
        checkOutput("t5_issue1_const", issue_at(1), 32'h0000_00A9);
        checkOutput("t5_issue2_const", issue_at(2), 32'h0000_00A2);
        checkOutput("t5_issue7_const", issue_at(7), 32'h0000_00A7);

        $display("[TB] reset in RUN cycle 3");
        x = DW'($urandom);
        @(negedge clk);
        start      = 1'b1;
        input_data = x;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t6_en_c3", 32'(nif.neuron_en), 1);
        checkOutput("t6_w_c3",  32'(nif.weight_out), 32'(mbank[3]));
        #2 reset_and_check("t6_rst");
        check_ignored("t6_after");
        for (int k = 0; k < N - 1; k++) load_byte(DW'($urandom));
        check_ignored("t6_seven");
        load_byte(DW'($urandom));
        run_and_check("t6_reload", DW'($urandom), 1'b0, '0);

        $display("[TB] randomized loads and runs");
        for (int it = 0; it < 6; it++) begin
            int nb;
            nb = $urandom_range(1, 12);
            for (int k = 0; k < nb; k++) load_byte(DW'($urandom));
            run_and_check($sformatf("rnd%0d", it), DW'($urandom), 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
